// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, datapath strobe and MDR signals of the shared memory port
interface mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic [1:0]    req;
    logic [1:0]    rw;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          MFC;
    logic          MAR_write;
    logic          MDR_write;
    logic          MDR_mem_read;
    logic          MEM_EN;
    logic          MEM_RW;
    logic [AW-1:0] mar_in;
    logic [DW-1:0] mdr_in;
    logic [DW-1:0] mdr_out;

    modport slave (
        input  req, rw, addr0, addr1, wdata0, wdata1, MFC, mdr_out,
        output gnt, done, rdata, err, MAR_write, MDR_write, MDR_mem_read,
               MEM_EN, MEM_RW, mar_in, mdr_in
    );

    modport master (
        output req, rw, addr0, addr1, wdata0, wdata1, MFC, mdr_out,
        input  gnt, done, rdata, err, MAR_write, MDR_write, MDR_mem_read,
               MEM_EN, MEM_RW, mar_in, mdr_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-requester sequencer for the MAR/MDR memory port
// Optional MFC watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int AW      = 6,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LATCH, ACCESS, COMPLETE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          sel;
    logic          tmo;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [3:0]    cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    assign bus.gnt = gnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= 4'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        last_d           = last_q;
        rw_d             = rw_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d            = 4'd0;
        tmo_d            = 1'b0;
`endif
        bus.done         = 2'b00;
        bus.rdata        = '0;
        bus.err          = 1'b0;
        bus.MAR_write    = 1'b0;
        bus.MDR_write    = 1'b0;
        bus.MDR_mem_read = 1'b0;
        bus.MEM_EN       = 1'b0;
        bus.MEM_RW       = 1'b0;
        bus.mar_in       = '0;
        bus.mdr_in       = '0;
        // On a tie the requester not served last wins; a lone request wins outright.
        sel = (bus.req == 2'b11) ? ~last_q : bus.req[1];

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    rw_d    = bus.rw[sel];
                    addr_d  = sel ? bus.addr1 : bus.addr0;
                    wdata_d = sel ? bus.wdata1 : bus.wdata0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bus.MAR_write = 1'b1;
                bus.mar_in    = addr_q;
                if (rw_q) begin
                    bus.MDR_write = 1'b1;
                    bus.mdr_in    = wdata_q;
                end
                state_d = ACCESS;
            end
            ACCESS: begin
                bus.MEM_EN = 1'b1;
                bus.MEM_RW = rw_q;
                if (!bus.MFC) begin
                    bus.MDR_mem_read = ~rw_q;
                    state_d          = COMPLETE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = COMPLETE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            COMPLETE: begin
                bus.done  = gnt_q;
                bus.rdata = (rw_q || tmo) ? '0 : bus.mdr_out;
                bus.err   = tmo;
                last_d    = gnt_q[1];
                gnt_d     = 2'b00;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table plus directed sequences for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(6), .DW(16)) bus ();

    mem_arbiter #(.AW(6), .DW(16), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {gnt, done, rdata, err, MAR_write, MDR_write, MDR_mem_read, MEM_EN, MEM_RW, mar_in, mdr_in}
    logic [47:0] obs;
    assign obs = {bus.gnt, bus.done, bus.rdata, bus.err, bus.MAR_write, bus.MDR_write,
                  bus.MDR_mem_read, bus.MEM_EN, bus.MEM_RW, bus.mar_in, bus.mdr_in};

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  rw;
        logic [5:0]  a0;
        logic [5:0]  a1;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        mfc;
        logic [15:0] mdr;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [47:0] ex(input logic [1:0] g, input logic [1:0] d,
                                       input logic [15:0] rd, input logic [5:0] f,
                                       input logic [5:0] mi, input logic [15:0] md);
        return {g, d, rd, f, mi, md};
    endfunction

    task automatic add(input logic [1:0] req, input logic [1:0] rw, input logic [5:0] a0,
                       input logic [5:0] a1, input logic [15:0] w0, input logic [15:0] w1,
                       input logic mfc, input logic [15:0] mdr, input logic [47:0] e);
        vec_t v;
        v = '{req, rw, a0, a1, w0, w1, mfc, mdr, e};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req = 2'b00; bus.rw = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.MFC = 1'b1; bus.mdr_out = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int first_done;
        int ndone;
        int en_cnt;
        logic got_done;
        logic bad_onehot;
        logic saw_err;
        logic [1:0] exp_seq [4];

        // flag bits: {err, MAR_write, MDR_write, MDR_mem_read, MEM_EN, MEM_RW}
        add(2'b01, 2'b00, 6'h3F, 6'h00, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, ex(2'b00, 2'b00, 16'h0, 6'b000000, 6'h00, 16'h0));
        add(2'b01, 2'b00, 6'h3F, 6'h00, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, ex(2'b01, 2'b00, 16'h0, 6'b010000, 6'h3F, 16'h0));
        add(2'b01, 2'b00, 6'h3F, 6'h00, 16'h0000, 16'h0000, 1'b0, 16'hA5A5, ex(2'b01, 2'b00, 16'h0, 6'b000110, 6'h00, 16'h0));
        add(2'b00, 2'b00, 6'h3F, 6'h00, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, ex(2'b01, 2'b01, 16'hA5A5, 6'b000000, 6'h00, 16'h0));
        add(2'b10, 2'b10, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b00, 2'b00, 16'h0, 6'b000000, 6'h00, 16'h0));
        add(2'b10, 2'b10, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b10, 2'b00, 16'h0, 6'b011000, 6'h01, 16'h1234));
        add(2'b10, 2'b10, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b10, 2'b00, 16'h0, 6'b000011, 6'h00, 16'h0));
        add(2'b10, 2'b10, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b10, 2'b00, 16'h0, 6'b000011, 6'h00, 16'h0));
        add(2'b10, 2'b10, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b10, 2'b00, 16'h0, 6'b000011, 6'h00, 16'h0));
        add(2'b10, 2'b10, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, ex(2'b10, 2'b00, 16'h0, 6'b000011, 6'h00, 16'h0));
        add(2'b00, 2'b10, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b10, 2'b10, 16'h0, 6'b000000, 6'h00, 16'h0));
        add(2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, ex(2'b00, 2'b00, 16'h0, 6'b000000, 6'h00, 16'h0));
        add(2'b01, 2'b01, 6'h0A, 6'h01, 16'hBEEF, 16'h1234, 1'b1, 16'hFFFF, ex(2'b00, 2'b00, 16'h0, 6'b000000, 6'h00, 16'h0));
        add(2'b00, 2'b01, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b01, 2'b00, 16'h0, 6'b011000, 6'h0A, 16'hBEEF));
        add(2'b00, 2'b01, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, ex(2'b01, 2'b00, 16'h0, 6'b000011, 6'h00, 16'h0));
        add(2'b00, 2'b01, 6'h00, 6'h01, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, ex(2'b01, 2'b01, 16'h0, 6'b000000, 6'h00, 16'h0));
        add(2'b00, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, ex(2'b00, 2'b00, 16'h0, 6'b000000, 6'h00, 16'h0));

        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", obs, 48'h0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            bus.req = tbl[i].req; bus.rw = tbl[i].rw;
            bus.addr0 = tbl[i].a0; bus.addr1 = tbl[i].a1;
            bus.wdata0 = tbl[i].w0; bus.wdata1 = tbl[i].w1;
            bus.MFC = tbl[i].mfc; bus.mdr_out = tbl[i].mdr;
            #1 check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // Contention: both requesters held, grants must alternate starting with requester 0.
        do_reset();
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        ndone = 0; first_done = -1; bad_onehot = 1'b0;
        for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
            @(negedge clk);
            bus.req = 2'b11; bus.MFC = 1'b0; bus.mdr_out = 16'h1111;
            #1;
            if (bus.gnt == 2'b11 || bus.done == 2'b11) bad_onehot = 1'b1;
            if (bus.done != 2'b00) begin
                if (first_done < 0) first_done = cyc;
                check($sformatf("rr_done%0d", ndone), {46'h0, bus.done}, {46'h0, exp_seq[ndone]});
                check($sformatf("rr_gnt%0d", ndone), {46'h0, bus.gnt}, {46'h0, exp_seq[ndone]});
                ndone++;
            end
        end
        check("rr_done_count", 48'(ndone), 48'd4);
        check("rr_latency", 48'(first_done), 48'd3);
        check("rr_onehot", {47'h0, bad_onehot}, 48'h0);

        // Asynchronous reset while in ACCESS, then a clean read.
        do_reset();
        @(negedge clk); bus.req = 2'b01; bus.rw = 2'b00; bus.addr0 = 6'h15; bus.MFC = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 check("pre_reset_mem_en", {47'h0, bus.MEM_EN}, 48'h1);
        #1 reset = 1'b0;
        #1 check("async_reset_outputs", obs, 48'h0);
        @(negedge clk);
        #1 check("reset_held_outputs", obs, 48'h0);
        reset = 1'b1;
        bus.MFC = 1'b0; bus.mdr_out = 16'h5A5A;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 10 && !got_done; cyc++) begin
            @(negedge clk);
            #1;
            if (bus.done != 2'b00) begin
                got_done = 1'b1;
                check("post_reset_done", {46'h0, bus.done}, 48'h1);
                check("post_reset_rdata", {32'h0, bus.rdata}, 48'h5A5A);
            end
        end
        check("post_reset_completed", {47'h0, got_done}, 48'h1);

        // MFC never arrives.
        do_reset();
        @(negedge clk); bus.req = 2'b01; bus.rw = 2'b00; bus.MFC = 1'b1; bus.mdr_out = 16'hFFFF;
        en_cnt = 0; got_done = 1'b0; saw_err = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            @(negedge clk);
            #1;
            if (bus.MEM_EN) en_cnt++;
            if (bus.err) saw_err = 1'b1;
            if (bus.done != 2'b00) begin
                got_done = 1'b1;
                check("tmo_done", {46'h0, bus.done}, 48'h1);
                check("tmo_err", {47'h0, bus.err}, 48'h1);
                check("tmo_rdata", {32'h0, bus.rdata}, 48'h0);
            end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        check("tmo_fired", {47'h0, got_done}, 48'h1);
        check("tmo_access_cycles", 48'(en_cnt), 48'd15);
`else
        check("wait_no_done", {47'h0, got_done}, 48'h0);
        check("wait_gnt_held", {46'h0, bus.gnt}, 48'h1);
        check("wait_no_err", {47'h0, saw_err}, 48'h0);
`endif
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
